// File: rtl/cmul_result_collector.sv
// cmul_result_collector: tracks in-flight complex multiplies, captures
// each {real[63:32], imag[31:0]} result into a show-ahead FIFO with credits.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ce                multiplier pipeline clock enable
//   issue             upstream presents an operand pair this cycle
//   issue_ready       credit available (reserved < DEPTH)
//   result_in         multiplier result bus {real, imag}
//   out_data          FIFO head {real, imag}
//   out_valid         FIFO non-empty
//   out_ready         downstream accepts head
//   level             FIFO occupancy
//   overflow          sticky: issue attempted with no credit
module cmul_result_collector #(
    parameter int LATENCY = 12,
    parameter int DEPTH   = 8,
    parameter int CW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          issue,
    output logic          issue_ready,
    input  logic [63:0]   result_in,
    output logic [63:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] level,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [LATENCY-1:0] r_tag;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_level;
    logic [CW-1:0]      r_reserved;
    logic               r_overflow;
    logic [63:0]        r_mem [DEPTH];

    logic w_credit;
    logic w_acc;
    logic w_wr;
    logic w_rd;
    logic w_valid;

    // Credits cover both in-flight tags and stored entries, so every
    // accepted operation is guaranteed a FIFO slot when it emerges.
    assign w_credit = (r_reserved < CW'(DEPTH));
    assign w_acc    = issue & w_credit & ce;
    // A tag parked at the tail while ce=0 waits for the next enabled edge.
    assign w_wr     = ce & r_tag[LATENCY-1];
    assign w_valid  = (r_level != '0);
    assign w_rd     = w_valid & out_ready;

    assign issue_ready = w_credit;
    assign out_valid   = w_valid;
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign out_data    = w_valid ? r_mem[r_rptr] : '0;

    // Tag delay line mirrors the ce-gated multiplier pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else if (ce) begin
            r_tag[0] <= w_acc;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level    <= '0;
            r_reserved <= '0;
        end else begin
            r_level    <= r_level + CW'(w_wr) - CW'(w_rd);
            r_reserved <= r_reserved + CW'(w_acc) - CW'(w_rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (issue & ce & ~w_credit) begin
            r_overflow <= 1'b1;
        end
    end

    // Storage is not reset; validity comes from the level counter.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= result_in;
        end
    end

`ifndef SYNTHESIS
    a_no_full_write: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_wr && !w_rd && (r_level == CW'(DEPTH))));

    a_reserved_bound: assert property (
        @(posedge clk) disable iff (!rst_n)
        r_reserved <= CW'(DEPTH));

    a_level_bound: assert property (
        @(posedge clk) disable iff (!rst_n)
        r_level <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_cmul_result_collector.sv
// tb_cmul_result_collector: scoreboard bench with a ce-gated multiplier
// model, a credit/latency reference model and a decoupled output monitor.
module tb_cmul_result_collector;

    localparam int LAT = 12;
    localparam int DEP = 8;
    localparam int CW  = $clog2(DEP) + 1;

    logic          clk;
    logic          rst_n;
    logic          ce;
    logic          issue;
    logic          issue_ready;
    logic [63:0]   result_in;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] level;
    logic          overflow;

    logic [63:0]   cur_data;
    logic [63:0]   pipe [LAT];

    int            n_chk;
    int            n_err;
    int            n_pop;

    int            ref_level;
    int            ref_res;
    bit            ref_ovf;
    int            inflight [$];
    logic [63:0]   exp_q [$];

    cmul_result_collector #(
        .LATENCY (LAT),
        .DEPTH   (DEP),
        .CW      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .issue       (issue),
        .issue_ready (issue_ready),
        .result_in   (result_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: ce-gated delay line; unissued slots carry junk.
    always @(posedge clk) begin
        if (ce) begin
            pipe[0] <= issue ? cur_data : {$urandom, $urandom};
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end
    assign result_in = pipe[LAT-1];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        ref_level = 0;
        ref_res   = 0;
        ref_ovf   = 1'b0;
        inflight.delete();
        exp_q.delete();
    endtask

    // Reference model: evaluated just before each rising edge.
    // Each accepted op needs LAT more enabled edges before it is stored.
    initial forever begin : model
        int  wrs;
        bit  rd;
        bit  acc;
        bit  cr;
        @(negedge clk);
        #4;
        if (rst_n) begin
            cr = (ref_res < DEP);
            chk("issue_ready", issue_ready, cr);
            chk("level", level, ref_level);
            chk("out_valid", out_valid, ref_level != 0);
            chk("overflow", overflow, ref_ovf);
            rd  = (ref_level > 0) && out_ready;
            acc = issue && ce && cr;
            if (issue && ce && !cr) ref_ovf = 1'b1;
            wrs = 0;
            if (ce) begin
                for (int i = 0; i < inflight.size(); i++) inflight[i]--;
                while (inflight.size() > 0 && inflight[0] == 0) begin
                    void'(inflight.pop_front());
                    wrs++;
                end
            end
            if (acc) begin
                inflight.push_back(LAT);
                exp_q.push_back(cur_data);
            end
            ref_level = ref_level + wrs - int'(rd);
            ref_res   = ref_res + int'(acc) - int'(rd);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over an entry.
    initial forever begin : monitor
        @(negedge clk);
        #4;
        if (rst_n && out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                chk("pop_on_empty_scoreboard", out_data, 64'hx);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic drive(input bit iss, input bit c, input bit rdy,
                         input logic [63:0] d);
        @(negedge clk);
        issue     = iss;
        ce        = c;
        out_ready = rdy;
        cur_data  = d;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_issue_ready"}, issue_ready, 1);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        issue     = 0;
        ce        = 0;
        out_ready = 0;
        rst_n     = 0;
        model_clear();
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_level(input int target, input int budget);
        bit hit;
        hit = 0;
        for (int k = 0; k < budget && !hit; k++) begin
            drive(0, 1, 0, rnd64());
            #2;
            if (level == target) hit = 1;
        end
        chk("wait_level", level, target);
    endtask

    int          lat_n;
    int          idx;
    int          guard;
    int          pops0;
    bit          iss;
    logic [63:0] d;

    initial begin
        n_chk = 0; n_err = 0; n_pop = 0;
        rst_n = 0; issue = 0; ce = 0; out_ready = 0; cur_data = '0;
        model_clear();

        // Single op: exact arrival cycle and bit-exact data.
        hard_reset();
        d = 64'h3F800000_40000000;
        drive(1, 1, 0, d);
        lat_n = 0;
        for (int k = 1; k <= 60 && lat_n == 0; k++) begin
            drive(0, 1, 0, rnd64());
            #2;
            if (out_valid) lat_n = k;
        end
        chk("single_latency", lat_n, LAT + 1);
        chk("single_data", out_data, d);
        chk("single_level", level, 1);
        drive(0, 1, 1, rnd64());
        drive(0, 1, 0, rnd64());
        #2;
        chk("single_pop_level", level, 0);
        chk("single_pop_valid", out_valid, 0);

        // ce stall of 5 cycles mid-flight.
        drive(1, 1, 0, rnd64());
        lat_n = 0;
        for (int k = 1; k <= 80 && lat_n == 0; k++) begin
            drive(0, !(k >= 4 && k < 9), 0, rnd64());
            #2;
            if (out_valid) lat_n = k;
        end
        chk("stall_latency", lat_n, LAT + 6);
        repeat (3) drive(0, 1, 0, rnd64());
        #2;
        chk("stall_single_write", level, 1);
        drive(0, 1, 1, rnd64());
        drive(0, 1, 0, rnd64());

        // Backpressure: 8 credits, then overflow attempt, then release.
        for (int k = 0; k < DEP; k++) drive(1, 1, 0, rnd64());
        drive(0, 1, 0, rnd64());
        #2;
        chk("bp_no_credit", issue_ready, 0);
        wait_level(DEP, 40);
        chk("bp_overflow_clear", overflow, 0);
        drive(1, 1, 0, rnd64());
        drive(0, 1, 0, rnd64());
        #2;
        chk("ovf_set", overflow, 1);
        repeat (LAT + 2) drive(0, 1, 0, rnd64());
        #2;
        chk("ovf_sticky", overflow, 1);
        chk("ovf_level_cap", level, DEP);
        drive(0, 1, 1, rnd64());
        drive(0, 1, 0, rnd64());
        #2;
        chk("bp_credit_back", issue_ready, 1);
        repeat (DEP + 2) drive(0, 1, 1, rnd64());

        // Streaming with wrap: imag carries the index.
        hard_reset();
        idx = 0; guard = 0; pops0 = n_pop;
        while (idx < 40 && guard < 1000) begin
            @(negedge clk);
            iss       = (ref_res < DEP);
            issue     = iss;
            ce        = 1;
            out_ready = 1;
            cur_data  = {$urandom, 32'(idx)};
            #2;
            chk("stream_level_le1", level <= 1, 1);
            if (iss) idx++;
            guard++;
        end
        repeat (LAT + 4) drive(0, 1, 1, rnd64());
        chk("stream_count", n_pop - pops0, 40);

        // Randomized traffic; occasional issue without credit.
        hard_reset();
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            iss = ($urandom % 4) != 0;
            if (ref_res >= DEP) iss = iss && (($urandom % 16) == 0);
            issue     = iss;
            ce        = ($urandom % 5) != 0;
            out_ready = ($urandom % 3) != 0;
            cur_data  = rnd64();
        end
        repeat (LAT + DEP + 6) drive(0, 1, 1, rnd64());
        chk("rand_drained", exp_q.size(), 0);

        // Asynchronous reset between edges with work in flight.
        hard_reset();
        drive(1, 1, 0, rnd64());
        drive(1, 1, 0, rnd64());
        wait_level(2, 40);
        repeat (3) drive(1, 1, 0, rnd64());
        drive(0, 1, 0, rnd64());
        #1;
        rst_n = 0;
        #1;
        check_reset_vals("async");
        model_clear();
        #1;
        rst_n = 1;
        repeat (LAT + 5) drive(0, 1, 1, rnd64());
        #2;
        chk("async_no_stale", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
